rd_rsp_arbiter: RTL and testbench
=================================

# rd_rsp_arbiter

Collects read responses from the NUM_SW_INST switch memory interfaces and arbitrates them round-robin onto a single registered response channel toward the rx side. Each read issued by the tx scheduler is tracked per switch: its op_id is captured at issue time and attached to the returned data. The per-switch pending mask is exported so the tx side can treat a switch with an outstanding read as busy.

## Interface
- NUM_SW_INST, 5, number of switch instances (≥2)
- W_WIDTH, 8, read data width
- RSP_TIMEOUT, 64, cycles a read may stay outstanding before an error response (used only with RSP_TIMEOUT_EN)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sel_en  in  NUM_SW_INST  one-hot issue strobe from the tx scheduler, one cycle per op
- wr_rd_s  in  1  op type qualifying sel_en: 1 = write, 0 = read
- op_id_in  in  8  op_id accompanying sel_en
- sw_rd_valid  in  NUM_SW_INST  per-switch read-data strobe, one cycle
- sw_rd_data  in  NUM_SW_INST*W_WIDTH  per-switch read data, slice i = [i*W_WIDTH +: W_WIDTH]
- rsp_valid  out  1  response channel valid
- rsp_ready  in  1  response channel ready
- rsp_data  out  W_WIDTH  response data
- rsp_op_id  out  8  op_id of the response
- rsp_sw_idx  out  $clog2(NUM_SW_INST)  source switch index
- rsp_err  out  1  response is a timeout (data forced 0)
- rd_pend  out  NUM_SW_INST  bit i high while slot i is not IDLE
- issue_ovf  out  1  sticky: a read was issued to a non-IDLE slot

## Operation
- One slot per switch; states IDLE, WAIT, HOLD. Each slot stores op_id (8b), data (W_WIDTH), err (1b).
- IDLE→WAIT: sel_en[i] & !wr_rd_s; op_id_in captured.
- Writes (wr_rd_s=1) never change slot state.
- Read issue to a WAIT/HOLD slot: dropped, slot contents unchanged, issue_ovf set (cleared only by reset).
- WAIT→HOLD: sw_rd_valid[i]; data captured, err=0.
- sw_rd_valid[i] while IDLE or HOLD: ignored.
- Same-cycle read issue and sw_rd_valid on an IDLE slot: issue taken, valid ignored.
- Arbiter: round-robin over HOLD slots, searching from pointer ptr upward with wrap NUM_SW_INST-1→0. ptr resets to 0.
- The output register is loadable when rsp_valid=0 or (rsp_valid & rsp_ready). On load, the winner's op_id/data/err/index go to the rsp_* outputs, the winner slot goes HOLD→IDLE, and ptr ← (winner+1) mod NUM_SW_INST.
- If the output register is loadable and no slot is HOLD, then rsp_valid goes to 0.
- rsp_* outputs are stable while rsp_valid & !rsp_ready.
- A slot freed by a load may accept a new read issue in the next cycle. A read issue in the same cycle as the load counts as an issue to a non-IDLE slot.
- Reset values: rsp_valid 0, rsp_data 0, rsp_op_id 0, rsp_sw_idx 0, rsp_err 0, rd_pend 0, issue_ovf 0, all slots IDLE, ptr 0.
- A reset mid-operation discards all outstanding and held responses. No response is produced for them.

## Timing
- Issue at edge k: rd_pend[i]=1 after edge k.
- sw_rd_valid at edge k: slot in HOLD after k. Earliest load is at edge k+1, so rsp_valid=1 after k+1. The minimum latency from sw_rd_valid to rsp_valid is 1 cycle.
- Sustained throughput is one response per cycle when rsp_ready is held high.
- rd_pend[i] stays high through HOLD and falls after the edge that loads slot i.
- Every output is registered.

## Configuration
- RSP_TIMEOUT_EN defined: each slot has a $clog2(RSP_TIMEOUT)+1 bit counter.
  - The counter clears on IDLE→WAIT and increments each WAIT cycle.
  - On the cycle the count equals RSP_TIMEOUT-1 with no sw_rd_valid, the slot goes to HOLD with err=1 and data=0.
  - A sw_rd_valid in that same cycle wins: normal data, err=0.
- RSP_TIMEOUT_EN undefined: there are no counters. WAIT persists until sw_rd_valid, and rsp_err is tied to 0.

## Test plan
- Single read: sel_en=5'b00100, wr_rd_s=0, op_id_in=8'h3C. Two cycles later sw_rd_valid[2] with data 8'hA5 and rsp_ready=1. Required response next cycle: rsp_valid=1, rsp_data=A5, rsp_op_id=3C, rsp_sw_idx=2, rsp_err=0. rd_pend[2] returns to 0.
- Round-robin: reads pending on switches 0, 1 and 4, with all three sw_rd_valid in the same cycle and rsp_ready=1. Required rsp_sw_idx order is 0, 1, 4 on consecutive cycles. Repeat with ptr=2: required order is 4, 0, 1.
- Backpressure: rsp_ready=0 for 5 cycles with two responses held. Required: rsp_* frozen on the first response and the second slot stays in HOLD. After release, both responses drain on consecutive cycles.
- Protocol checks:
  - A second read to switch 3 while it is in WAIT gives issue_ovf=1, and the original op_id is returned.
  - A write (wr_rd_s=1) to switch 3 leaves rd_pend unchanged.
  - An unsolicited sw_rd_valid[1] produces no response.
- Timeout (RSP_TIMEOUT_EN, RSP_TIMEOUT=8): a read on switch 0 with no sw_rd_valid. Required response 8–9 cycles after issue: rsp_err=1, rsp_data=0, correct op_id. Without the macro, no response ever appears.
- Reset mid-operation: rst_n=0 for 1 cycle with three slots in HOLD and rsp_valid=1. Required: all outputs return to their reset values and no stale response appears afterward.

Source files
------------

// File: rtl/rd_rsp_if.sv
// Read-response arbiter bus: tx-side issue strobes, per-switch read returns,
// and the single arbitrated response channel toward rx.
interface rd_rsp_if #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8
);
    localparam int IDX_W = $clog2(NUM_SW_INST);

    logic [NUM_SW_INST-1:0]         sel_en;
    logic                           wr_rd_s;
    logic [7:0]                     op_id_in;
    logic [NUM_SW_INST-1:0]         sw_rd_valid;
    logic [NUM_SW_INST*W_WIDTH-1:0] sw_rd_data;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [W_WIDTH-1:0]             rsp_data;
    logic [7:0]                     rsp_op_id;
    logic [IDX_W-1:0]               rsp_sw_idx;
    logic                           rsp_err;
    logic [NUM_SW_INST-1:0]         rd_pend;
    logic                           issue_ovf;

    modport master (
        output sel_en, wr_rd_s, op_id_in, sw_rd_valid, sw_rd_data, rsp_ready,
        input  rsp_valid, rsp_data, rsp_op_id, rsp_sw_idx, rsp_err, rd_pend, issue_ovf
    );

    modport slave (
        input  sel_en, wr_rd_s, op_id_in, sw_rd_valid, sw_rd_data, rsp_ready,
        output rsp_valid, rsp_data, rsp_op_id, rsp_sw_idx, rsp_err, rd_pend, issue_ovf
    );
endinterface

// File: rtl/rd_rsp_arbiter.sv
// Per-switch read tracking slots plus a round-robin arbiter onto one registered
// response channel. Define RSP_TIMEOUT_EN to enable per-slot timeout error responses.
module rd_rsp_slot #(
    parameter int W_WIDTH = 8
`ifdef RSP_TIMEOUT_EN
    ,
    parameter int RSP_TIMEOUT = 64
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue,
    input  logic [7:0]         op_id_in,
    input  logic               rd_valid,
    input  logic [W_WIDTH-1:0] rd_data,
    input  logic               grant,
    output logic               hold,
    output logic               pend,
    output logic               ovf_hit,
    output logic [7:0]         op_id,
    output logic [W_WIDTH-1:0] data,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t state, state_nxt;
    logic   start, cap_rd, cap_to, tmo;

`ifdef RSP_TIMEOUT_EN
    localparam int CW = $clog2(RSP_TIMEOUT) + 1;
    logic [CW-1:0] cnt;

    assign tmo = (state == WAIT) && (cnt == CW'(RSP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)              cnt <= '0;
        else if (start)          cnt <= '0;
        else if (state == WAIT)  cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      err <= 1'b0;
        else if (cap_rd) err <= 1'b0;
        else if (cap_to) err <= 1'b1;
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        cap_rd    = 1'b0;
        cap_to    = 1'b0;
        case (state)
            IDLE: if (issue) begin state_nxt = WAIT; start = 1'b1; end
            // real data beats a timeout landing in the same cycle
            WAIT: if (rd_valid) begin state_nxt = HOLD; cap_rd = 1'b1; end
                  else if (tmo) begin state_nxt = HOLD; cap_to = 1'b1; end
            HOLD: if (grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hold    = (state == HOLD);
    assign ovf_hit = issue && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= 1'b0;
            op_id <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= (state_nxt != IDLE);
            if (start)       op_id <= op_id_in;
            if (cap_rd)      data  <= rd_data;
            else if (cap_to) data  <= '0;
        end
    end
endmodule

module rd_rsp_arbiter #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int RSP_TIMEOUT = 64
) (
    input logic    clk,
    input logic    rst_n,
    rd_rsp_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SW_INST);

    if (NUM_SW_INST < 2 || RSP_TIMEOUT < 2) begin : g_bad_cfg
        $error("rd_rsp_arbiter: NUM_SW_INST and RSP_TIMEOUT must be >= 2");
    end

    logic [NUM_SW_INST-1:0]              issue, hold, pend, ovf_hit, grant, slot_err;
    logic [NUM_SW_INST-1:0][7:0]         slot_id;
    logic [NUM_SW_INST-1:0][W_WIDTH-1:0] slot_data;

    assign issue = bus.sel_en & {NUM_SW_INST{~bus.wr_rd_s}};

    for (genvar i = 0; i < NUM_SW_INST; i++) begin : g_slot
        rd_rsp_slot #(
            .W_WIDTH(W_WIDTH)
`ifdef RSP_TIMEOUT_EN
            , .RSP_TIMEOUT(RSP_TIMEOUT)
`endif
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .issue    (issue[i]),
            .op_id_in (bus.op_id_in),
            .rd_valid (bus.sw_rd_valid[i]),
            .rd_data  (bus.sw_rd_data[i*W_WIDTH +: W_WIDTH]),
            .grant    (grant[i]),
            .hold     (hold[i]),
            .pend     (pend[i]),
            .ovf_hit  (ovf_hit[i]),
            .op_id    (slot_id[i]),
            .data     (slot_data[i]),
            .err      (slot_err[i])
        );
    end

    logic               rsp_valid, rsp_err, issue_ovf, found, load;
    logic [W_WIDTH-1:0] rsp_data;
    logic [7:0]         rsp_op_id;
    logic [IDX_W-1:0]   rsp_sw_idx, ptr, win;
    logic [IDX_W:0]     scan;

    // first HOLD slot at or above ptr, wrapping at NUM_SW_INST
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_SW_INST; k++) begin
            scan = {1'b0, ptr} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_SW_INST)) scan = scan - (IDX_W+1)'(NUM_SW_INST);
            if (!found && hold[scan[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = scan[IDX_W-1:0];
            end
        end
    end

    assign load = found && (!rsp_valid || bus.rsp_ready);

    always_comb begin
        grant      = '0;
        grant[win] = load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_op_id  <= '0;
            rsp_sw_idx <= '0;
            rsp_err    <= 1'b0;
            issue_ovf  <= 1'b0;
            ptr        <= '0;
        end else begin
            if (|ovf_hit) issue_ovf <= 1'b1;
            if (!rsp_valid || bus.rsp_ready) rsp_valid <= found;
            if (load) begin
                rsp_data   <= slot_data[win];
                rsp_op_id  <= slot_id[win];
                rsp_err    <= slot_err[win];
                rsp_sw_idx <= win;
                ptr        <= (win == IDX_W'(NUM_SW_INST - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_op_id  = rsp_op_id;
    assign bus.rsp_sw_idx = rsp_sw_idx;
    assign bus.rsp_err    = rsp_err;
    assign bus.rd_pend    = pend;
    assign bus.issue_ovf  = issue_ovf;
endmodule

// File: tb/tb_rd_rsp_arbiter.sv
// Bench for rd_rsp_arbiter: vector table of single reads plus hand-written
// round-robin, backpressure, protocol, timeout and reset sequences, scoreboarded.
module tb_rd_rsp_arbiter;
    localparam int N = 5;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rd_rsp_if #(.NUM_SW_INST(N), .W_WIDTH(W)) bus ();

    rd_rsp_arbiter #(.NUM_SW_INST(N), .W_WIDTH(W), .RSP_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]   op;
        logic [W-1:0] data;
        logic [2:0]   idx;
        logic         err;
    } rsp_t;

    typedef struct {
        int         sw;
        logic [7:0] op;
        logic [7:0] data;
        int         gap;
    } vec_t;

    rsp_t sbq[$];
    rsp_t exp_r;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // scoreboard: every handshake must match the oldest expected response
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got idx %0d op %0h, expected no response at %0t",
                         bus.rsp_sw_idx, bus.rsp_op_id, $time);
            end else begin
                exp_r = sbq.pop_front();
                chk("rsp_op_id",  bus.rsp_op_id,  exp_r.op);
                chk("rsp_data",   bus.rsp_data,   exp_r.data);
                chk("rsp_sw_idx", bus.rsp_sw_idx, exp_r.idx);
                chk("rsp_err",    bus.rsp_err,    exp_r.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int sw, input logic [7:0] op, input logic wr);
        bus.sel_en     = '0;
        bus.sel_en[sw] = 1'b1;
        bus.wr_rd_s    = wr;
        bus.op_id_in   = op;
        tick();
        bus.sel_en  = '0;
        bus.wr_rd_s = 1'b0;
    endtask

    task automatic set_data(input int sw, input logic [7:0] d);
        bus.sw_rd_data[sw*W +: W] = d;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        bus.sw_rd_valid = m;
        tick();
        bus.sw_rd_valid = '0;
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] d, input int idx, input logic e);
        sbq.push_back('{op: op, data: d, idx: 3'(idx), err: e});
    endtask

    task automatic do_rr(input int o0, input int o1, input int o2);
        int ord[3];
        ord = '{o0, o1, o2};
        issue(0, 8'h10, 1'b0);
        issue(1, 8'h11, 1'b0);
        issue(4, 8'h14, 1'b0);
        set_data(0, 8'hD0);
        set_data(1, 8'hD1);
        set_data(4, 8'hD4);
        for (int k = 0; k < 3; k++) push(8'h10 + 8'(ord[k]), 8'hD0 + 8'(ord[k]), ord[k], 1'b0);
        pulse(5'b10011);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr_valid_consec", bus.rsp_valid, 1);
            chk("rr_order_idx", bus.rsp_sw_idx, ord[k]);
        end
        tick();
        chk("rr_drained", bus.rsp_valid, 0);
    endtask

    vec_t vt[5];
    logic [N-1:0] one;

    initial begin
        vt[0] = '{2, 8'h3C, 8'hA5, 2};
        vt[1] = '{0, 8'h01, 8'h00, 0};
        vt[2] = '{3, 8'hFF, 8'hFF, 3};
        vt[3] = '{1, 8'h80, 8'h5A, 1};
        vt[4] = '{4, 8'h7E, 8'hC3, 4};

        rst_n           = 1'b0;
        bus.sel_en      = '0;
        bus.wr_rd_s     = 1'b0;
        bus.op_id_in    = '0;
        bus.sw_rd_valid = '0;
        bus.sw_rd_data  = '0;
        bus.rsp_ready   = 1'b1;
        tick();
        tick();
        chk("rst_rsp_valid",  bus.rsp_valid,  0);
        chk("rst_rsp_data",   bus.rsp_data,   0);
        chk("rst_rsp_op_id",  bus.rsp_op_id,  0);
        chk("rst_rsp_sw_idx", bus.rsp_sw_idx, 0);
        chk("rst_rsp_err",    bus.rsp_err,    0);
        chk("rst_rd_pend",    bus.rd_pend,    0);
        chk("rst_issue_ovf",  bus.issue_ovf,  0);
        rst_n = 1'b1;
        tick();

        // single reads, one-cycle latency from sw_rd_valid to rsp_valid
        for (int v = 0; v < 5; v++) begin
            one = '0;
            one[vt[v].sw] = 1'b1;
            issue(vt[v].sw, vt[v].op, 1'b0);
            chk("pend_after_issue", bus.rd_pend, one);
            repeat (vt[v].gap) tick();
            bus.sw_rd_data = '0;
            set_data(vt[v].sw, vt[v].data);
            push(vt[v].op, vt[v].data, vt[v].sw, 1'b0);
            pulse(one);
            chk("no_early_valid", bus.rsp_valid, 0);
            chk("pend_in_hold", bus.rd_pend, one);
            tick();
            chk("rsp_valid_lat1", bus.rsp_valid, 1);
            chk("pend_cleared", bus.rd_pend, 0);
            tick();
            chk("rsp_valid_drop", bus.rsp_valid, 0);
        end

        // last winner was 4, so ptr is 0
        do_rr(0, 1, 4);
        issue(1, 8'h21, 1'b0);
        set_data(1, 8'h61);
        push(8'h21, 8'h61, 1, 1'b0);
        pulse(5'b00010);
        tick();
        tick();
        do_rr(4, 0, 1);

        // backpressure: ptr is 2 here
        bus.rsp_ready = 1'b0;
        issue(2, 8'h32, 1'b0);
        issue(3, 8'h33, 1'b0);
        set_data(2, 8'hB2);
        set_data(3, 8'hB3);
        push(8'h32, 8'hB2, 2, 1'b0);
        push(8'h33, 8'hB3, 3, 1'b0);
        pulse(5'b01100);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid",  bus.rsp_valid,  1);
            chk("bp_idx",    bus.rsp_sw_idx, 2);
            chk("bp_op",     bus.rsp_op_id,  8'h32);
            chk("bp_data",   bus.rsp_data,   8'hB2);
            chk("bp_pend",   bus.rd_pend,    5'b01000);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_second_valid", bus.rsp_valid, 1);
        chk("bp_second_idx", bus.rsp_sw_idx, 3);
        tick();
        chk("bp_drained", bus.rsp_valid, 0);
        chk("bp_pend_clear", bus.rd_pend, 0);

        // protocol: double read, writes, unsolicited data
        issue(3, 8'h11, 1'b0);
        chk("ovf_clear", bus.issue_ovf, 0);
        issue(3, 8'h22, 1'b0);
        chk("ovf_set", bus.issue_ovf, 1);
        chk("ovf_pend", bus.rd_pend, 5'b01000);
        issue(3, 8'h99, 1'b1);
        chk("write_busy_pend", bus.rd_pend, 5'b01000);
        issue(1, 8'h55, 1'b1);
        chk("write_idle_pend", bus.rd_pend, 5'b01000);
        set_data(3, 8'h77);
        push(8'h11, 8'h77, 3, 1'b0);
        pulse(5'b01000);
        tick();
        chk("ovf_orig_op", bus.rsp_op_id, 8'h11);
        tick();
        set_data(1, 8'hEE);
        pulse(5'b00010);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("unsolicited_none", bus.rsp_valid, 0);
        end
        chk("unsolicited_pend", bus.rd_pend, 0);
        chk("ovf_sticky", bus.issue_ovf, 1);

        // timeout on switch 0
        issue(0, 8'h0A, 1'b0);
`ifdef RSP_TIMEOUT_EN
        push(8'h0A, 8'h00, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("tmo_not_yet", bus.rsp_valid, 0);
            tick();
        end
        chk("tmo_not_yet", bus.rsp_valid, 0);
        tick();
        chk("tmo_valid", bus.rsp_valid, 1);
        chk("tmo_err", bus.rsp_err, 1);
        chk("tmo_data", bus.rsp_data, 0);
        tick();
        chk("tmo_drained", bus.rsp_valid, 0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("no_tmo_rsp", bus.rsp_valid, 0);
        end
        chk("no_tmo_pend", bus.rd_pend, 5'b00001);
`endif

        // reset with three slots holding and a response stalled
        bus.rsp_ready = 1'b0;
        issue(1, 8'h41, 1'b0);
        issue(2, 8'h42, 1'b0);
        issue(3, 8'h43, 1'b0);
        issue(4, 8'h44, 1'b0);
        pulse(5'b11110);
        tick();
        chk("pre_rst_valid", bus.rsp_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid",  bus.rsp_valid,  0);
        chk("mid_rst_data",   bus.rsp_data,   0);
        chk("mid_rst_op_id",  bus.rsp_op_id,  0);
        chk("mid_rst_sw_idx", bus.rsp_sw_idx, 0);
        chk("mid_rst_err",    bus.rsp_err,    0);
        chk("mid_rst_pend",   bus.rd_pend,    0);
        chk("mid_rst_ovf",    bus.issue_ovf,  0);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("no_stale_rsp", bus.rsp_valid, 0);
        end

        // ptr back at 0 after reset
        issue(2, 8'h62, 1'b0);
        issue(0, 8'h60, 1'b0);
        set_data(0, 8'hF0);
        set_data(2, 8'hF2);
        push(8'h60, 8'hF0, 0, 1'b0);
        push(8'h62, 8'hF2, 2, 1'b0);
        pulse(5'b00101);
        tick();
        chk("post_rst_first", bus.rsp_sw_idx, 0);
        tick();
        chk("post_rst_second", bus.rsp_sw_idx, 2);
        tick();
        chk("post_rst_drained", bus.rsp_valid, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
